// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, STOP} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one imem request at a time and presenting the fetched instruction downstream
//   clk, rst_n (async active-low); next_pc, halt from control; imem_req/addr/gnt/rvalid/rdata memory port;
//   if_valid/if_ready/if_pc/if_instr downstream port; fault (sticky misaligned PC); fetch_count (accepted instructions)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fault,
  output logic [31:0] fetch_count
);
  fetch_state_t state, state_nx;
  logic [31:0] pc;
  logic accept, misaligned;
  assign accept = (state == HOLD) && if_ready;
  assign misaligned = |next_pc[1:0];
  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT: state_nx = halt ? STOP : REQ;
      REQ:  state_nx = imem_gnt ? WAIT : REQ;
      WAIT: state_nx = imem_rvalid ? HOLD : WAIT;
      HOLD: state_nx = accept ? ((misaligned || halt) ? STOP : REQ) : HOLD;
      STOP: state_nx = (!halt && !fault) ? REQ : STOP;
      default: state_nx = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_instr    <= NOP_INSTR;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_nx;
      if (accept && !misaligned) pc <= next_pc;
      if (state == WAIT && imem_rvalid) if_instr <= imem_rdata;
      if (accept) fetch_count <= fetch_count + 32'd1;
      if (accept && misaligned) fault <= 1'b1;
    end
  end
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign if_pc     = pc;
  assign if_valid  = (state == HOLD);
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter and feeds the next-PC logic and the decoder. It holds the current PC and issues one request at a time to instruction memory over a req/gnt/rvalid handshake. It presents the returned instruction with its PC to downstream. On acceptance it loads the PC from the next-PC logic's `next` output, which is computed from `if_pc` and `if_instr`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `next_pc`  input  32  next PC from the next-PC logic; sampled only on the accept cycle.
- `halt`  input  1  suppresses new memory requests while high.
- `imem_req`  output  1  instruction-memory request.
- `imem_addr`  output  32  request address; always equals the PC register.
- `imem_gnt`  input  1  memory accepted the request this cycle.
- `imem_rvalid`  input  1  read data valid.
- `imem_rdata`  input  32  instruction word.
- `if_valid`  output  1  `if_instr`/`if_pc` hold a fetched instruction.
- `if_ready`  input  1  downstream accepts the instruction this cycle.
- `if_pc`  output  32  PC of the presented instruction; equals the PC register.
- `if_instr`  output  32  fetched instruction, registered.
- `fault`  output  1  sticky misaligned-PC fault.
- `fetch_count`  output  32  number of instructions accepted since reset; wraps at 2^32.

## Operation
- States: BOOT, REQ, WAIT, HOLD, STOP.
- BOOT:
  - Entered on reset.
  - Leaves to REQ on the first clock edge after `rst_n` rises, or to STOP if `halt`=1.
- REQ:
  - `imem_req`=1 and `imem_addr` is held stable until `imem_gnt`=1.
  - On gnt, go to WAIT.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`=1, capture `imem_rdata` into `if_instr` and go to HOLD.
  - `imem_rvalid` in any other state is ignored.
  - rvalid never arrives in the gnt cycle; the earliest is the following cycle.
- HOLD:
  - `if_valid`=1.
  - An accept (`if_valid && if_ready`) performs three updates:
    - the PC register loads `next_pc`;
    - `fetch_count` increments;
    - the FSM goes to REQ, or to STOP if `halt`=1.
- Misaligned PC: if `next_pc[1:0]`≠0 on accept, the block goes to STOP, sets `fault`, and does not load the PC. `fault` stays set until reset.
- STOP:
  - `imem_req`=0 and `if_valid`=0.
  - Leaves to REQ when `halt`=0 and `fault`=0.
- `halt` never aborts an outstanding request. It takes effect only at BOOT exit or at accept.
- `if_instr` and `if_pc` are stable whenever `if_valid`=1 and `if_ready`=0.

## Timing
- Reset values (applied asynchronously):
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=`RESET_PC`;
  - `if_instr`=32'h0000_0000 (NOP), `fault`=0, `fetch_count`=0, state BOOT.
- First `imem_req` is high in the cycle after the first post-reset edge.
- Best case is 3 cycles per instruction: REQ with gnt, WAIT with rvalid, HOLD with ready.
- `if_valid` rises in the cycle after rvalid. The new `imem_req` rises in the cycle after accept.
- Reset asserted mid-operation (REQ, WAIT or HOLD): all outputs return to reset values immediately, and a late rvalid from the aborted request is dropped.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0.

## Structure
- Shared package `fetch_pkg` contains:
  - the state enum (BOOT/REQ/WAIT/HOLD/STOP);
  - `NOP_INSTR`=32'h0000_0000;
  - the default reset PC constant.
- Single module, no sub-modules. The FSM, PC register, instruction register and counter all sit inline.

## Test plan
- Reset release with `RESET_PC`=0x0040_0000, immediate gnt, rvalid one cycle later with data 0x2008_0005 -> `imem_req` high 1 cycle after release with addr 0x0040_0000; then `if_valid`=1, `if_instr`=0x2008_0005, `if_pc`=0x0040_0000.
- Accept with `next_pc`=0x0040_0004 -> next request at 0x0040_0004, `fetch_count`=1.
- gnt delayed 3 cycles -> `imem_req` and `imem_addr` held constant for 4 cycles, no duplicate request; `if_ready` low 5 cycles in HOLD -> outputs stable, `imem_req`=0 throughout.
- Accept with `next_pc`=0x0040_0006 -> `fault`=1, `if_pc` unchanged, no further `imem_req` until `rst_n` pulses low.
- `halt` raised during WAIT -> instruction still delivered; after accept, STOP with no request; `halt` low -> request at the captured `next_pc`.
- `rst_n` low during WAIT, then rvalid while in BOOT -> outputs at reset values; `if_instr` stays 0; fetch restarts at `RESET_PC`.
